// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, issuer state encoding and the
//               error result word for the 4-bit ALU command issuer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes (4-bit sel field of the attached combinational ALU)
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_MOD  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_PASS = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_INC  = 4'b1110;
    localparam logic [3:0] OP_DEC  = 4'b1111;

    // Result word returned when a divide/modulo by zero is trapped
    localparam logic [15:0] ERR_RESULT = 16'hFFFF;

    // Issuer state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KICK   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // True for the opcodes that would fault on a zero divisor
    function automatic logic is_div_op(input logic [3:0] sel);
        return (sel == OP_DIV) || (sel == OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Accepts ALU commands over valid/ready, drives the attached
//               combinational ALU (with an inverted-opcode kick so it always
//               re-evaluates), captures the result after a settle window and
//               returns it over a second valid/ready handshake. Traps
//               divide/modulo by zero, supports result chaining and counts
//               completed operations.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_chain,
    output logic [3:0]       alu_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [15:0]      alu_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [3:0]       c_settle_init = 4'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_sel;
    logic [3:0]       r_cnt;
    logic [3:0]       r_last_res;   // only the low nibble can ever be chained
    logic [3:0]       r_alu_sel;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic             r_res_valid;
    logic [15:0]      r_res_data;
    logic             r_res_err;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_accept;
    logic             w_div0;
    logic             w_handoff;
    logic [3:0]       w_a;

    assign cmd_ready = (r_state == ST_IDLE) & ~rst;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_a       = cmd_chain ? r_last_res : cmd_a;
    assign w_div0    = is_div_op(cmd_sel) && (cmd_b == 4'h0);
    assign w_handoff = (r_state == ST_RESP) & r_res_valid & res_ready;

    assign alu_sel   = r_alu_sel;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign op_cnt    = r_op_cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = w_div0 ? ST_RESP : ST_KICK;
            ST_KICK:   w_state_next = ST_SETTLE;
            ST_SETTLE: if (r_cnt == 4'd1) w_state_next = ST_RESP;
            ST_RESP:   if (w_handoff) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: ALU drive, settle counter, result capture and hand-off count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel       <= 4'h0;
            r_cnt       <= 4'h0;
            r_last_res  <= 4'h0;
            r_alu_sel   <= 4'h0;
            r_alu_a     <= 4'h0;
            r_alu_b     <= 4'h0;
            r_res_valid <= 1'b0;
            r_res_data  <= 16'h0000;
            r_res_err   <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel <= cmd_sel;
                        if (w_div0) begin
                            // Trapped: ALU is left alone, valid follows next edge
                            r_res_data <= ERR_RESULT;
                            r_res_err  <= 1'b1;
                        end else begin
                            // Inverted opcode first so the ALU sees a sel change
                            r_alu_a   <= w_a;
                            r_alu_b   <= cmd_b;
                            r_alu_sel <= ~cmd_sel;
                        end
                    end
                end
                ST_KICK: begin
                    r_alu_sel <= r_sel;
                    r_cnt     <= c_settle_init;
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_res_data  <= alu_op;
                        r_last_res  <= alu_op[3:0];
                        r_res_err   <= 1'b0;
                        r_res_valid <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_handoff) begin
                        r_res_valid <= 1'b0;
                        r_op_cnt    <= r_op_cnt + c_cnt_one;
                    end else if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_issuer
// Description : Directed self-checking bench for alu_cmd_issuer, with a
//               behavioural model of the attached ALU that only re-evaluates
//               when its sel input changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int SETTLE = 1;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_chain;
    logic [3:0]    cmd_sel, cmd_a, cmd_b;
    logic [3:0]    alu_sel, alu_a, alu_b;
    logic [15:0]   alu_op = 16'h0000;
    logic          res_valid, res_ready, res_err;
    logic [15:0]   res_data;
    logic [CW-1:0] op_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.SETTLE_CYC(SETTLE), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .op_cnt(op_cnt)
    );

    // Attached ALU: result only recomputed when sel changes
    always @(alu_sel) begin
        case (alu_sel)
            OP_ADD:  alu_op = {12'h0, alu_a} + {12'h0, alu_b};
            OP_SUB:  alu_op = {12'h0, alu_a} - {12'h0, alu_b};
            OP_MUL:  alu_op = {12'h0, alu_a} * {12'h0, alu_b};
            OP_DIV:  alu_op = (alu_b == 4'h0) ? 16'hFFFF : {12'h0, alu_a / alu_b};
            OP_MOD:  alu_op = (alu_b == 4'h0) ? 16'hFFFF : {12'h0, alu_a % alu_b};
            OP_AND:  alu_op = {12'h0, alu_a & alu_b};
            OP_OR:   alu_op = {12'h0, alu_a | alu_b};
            OP_XOR:  alu_op = {12'h0, alu_a ^ alu_b};
            OP_NOR:  alu_op = {12'h0, ~(alu_a | alu_b)};
            OP_XNOR: alu_op = {12'h0, ~(alu_a ^ alu_b)};
            OP_NOT:  alu_op = {12'h0, ~alu_a};
            OP_PASS: alu_op = {12'h0, alu_a};
            OP_SHL:  alu_op = {12'h0, alu_a} << 1;
            OP_SHR:  alu_op = {12'h0, alu_a >> 1};
            OP_INC:  alu_op = {12'h0, alu_a} + 16'd1;
            OP_DEC:  alu_op = {12'h0, alu_a} - 16'd1;
            default: alu_op = 16'h0000;
        endcase
    end

    // Present a command and return #1 after the edge that accepts it
    task automatic issue(input logic [3:0] s, input logic [3:0] a,
                         input logic [3:0] b, input logic ch);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_chain = ch;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_sel = 4'h9; cmd_a = 4'hE; cmd_b = 4'hD; cmd_chain = 1'b0;
    endtask

    // Edges from accept until res_valid is seen (bounded; 40 means expired)
    task automatic wait_res(output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // One-cycle res_ready pulse; returns #1 after the hand-off edge
    task automatic handoff();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 4'h0; cmd_a = 4'h0; cmd_b = 4'h0;
        cmd_chain = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        tests++; if ({res_valid, res_err, res_data} !== 18'h0) begin fails++; $display("FAIL reset_res: got v=%b e=%b d=%h want 0/0/0000", res_valid, res_err, res_data); end
        tests++; if ({alu_sel, alu_a, alu_b, op_cnt} !== 20'h0) begin fails++; $display("FAIL reset_alu_cnt: got sel=%h a=%h b=%h cnt=%0d want all 0", alu_sel, alu_a, alu_b, op_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_basic_add();
        issue(OP_ADD, 4'd3, 4'd5, 1'b0);
        tests++; if (alu_sel !== 4'b1111) begin fails++; $display("FAIL basic_kick_sel: got %b want 1111", alu_sel); end
        @(posedge clk); #1;
        tests++; if (alu_sel !== 4'b0000 || res_valid !== 1'b0) begin fails++; $display("FAIL basic_settle: got sel=%b v=%b want 0000/0", alu_sel, res_valid); end
        @(posedge clk); #1;
        tests++; if (res_valid !== 1'b1 || res_data !== 16'h0008 || res_err !== 1'b0) begin fails++; $display("FAIL basic_result: got v=%b d=%h e=%b want 1/0008/0", res_valid, res_data, res_err); end
        handoff();
        tests++; if (op_cnt !== 8'd1 || res_valid !== 1'b0) begin fails++; $display("FAIL basic_handoff: got cnt=%0d v=%b want 1/0", op_cnt, res_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(OP_MUL, 4'd3, 4'd4, 1'b0);
        wait_res(lat);
        tests++; if (lat != 2 || res_data !== 16'h000C) begin fails++; $display("FAIL b2b_first: got lat=%0d d=%h want 2/000C", lat, res_data); end
        handoff();
        issue(OP_MUL, 4'd2, 4'd7, 1'b0);
        wait_res(lat);
        tests++; if (lat != 2 || res_data !== 16'h000E) begin fails++; $display("FAIL b2b_second: got lat=%0d d=%h want 2/000E", lat, res_data); end
        handoff();
        tests++; if (op_cnt !== 8'd3) begin fails++; $display("FAIL b2b_cnt: got %0d want 3", op_cnt); end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(OP_DIV, 4'd9, 4'd0, 1'b0);
        wait_res(lat);
        tests++; if (lat != 1 || res_data !== 16'hFFFF || res_err !== 1'b1) begin fails++; $display("FAIL div0_resp: got lat=%0d d=%h e=%b want 1/FFFF/1", lat, res_data, res_err); end
        tests++; if (alu_sel !== 4'b0010 || alu_a !== 4'd2 || alu_b !== 4'd7) begin fails++; $display("FAIL div0_alu_hold: got sel=%b a=%0d b=%0d want 0010/2/7", alu_sel, alu_a, alu_b); end
        handoff();
        issue(OP_MOD, 4'd9, 4'd0, 1'b0);
        wait_res(lat);
        tests++; if (lat != 1 || res_data !== 16'hFFFF || res_err !== 1'b1) begin fails++; $display("FAIL mod0_resp: got lat=%0d d=%h e=%b want 1/FFFF/1", lat, res_data, res_err); end
        tests++; if (alu_sel !== 4'b0010 || alu_a !== 4'd2 || alu_b !== 4'd7) begin fails++; $display("FAIL mod0_alu_hold: got sel=%b a=%0d b=%0d want 0010/2/7", alu_sel, alu_a, alu_b); end
        handoff();
        tests++; if (op_cnt !== 8'd5) begin fails++; $display("FAIL div0_cnt: got %0d want 5", op_cnt); end
    endtask

    task automatic test_chain();
        int lat;
        issue(OP_ADD, 4'd2, 4'd3, 1'b0);
        wait_res(lat);
        tests++; if (res_data !== 16'h0005) begin fails++; $display("FAIL chain_seed: got %h want 0005", res_data); end
        handoff();
        issue(OP_SHL, 4'hE, 4'd0, 1'b1);
        tests++; if (alu_a !== 4'd5 || alu_sel !== 4'b0011) begin fails++; $display("FAIL chain_operand: got a=%0d sel=%b want 5/0011", alu_a, alu_sel); end
        wait_res(lat);
        tests++; if (lat != 2 || res_data !== 16'h000A || res_err !== 1'b0) begin fails++; $display("FAIL chain_result: got lat=%0d d=%h e=%b want 2/000A/0", lat, res_data, res_err); end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        issue(OP_SUB, 4'd3, 4'd5, 1'b0);
        wait_res(lat);
        tests++; if (lat != 2 || res_data !== 16'hFFFE || res_err !== 1'b0) begin fails++; $display("FAIL bp_underflow: got lat=%0d d=%h e=%b want 2/FFFE/0", lat, res_data, res_err); end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_sel = OP_ADD; cmd_a = 4'd1; cmd_b = 4'd1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || res_data !== 16'hFFFE || cmd_ready !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold: got %0d unstable cycles want 0 (v=%b d=%h rdy=%b)", bad, res_valid, res_data, cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        handoff();
        tests++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || op_cnt !== 8'd8) begin fails++; $display("FAIL bp_release: got rdy=%b v=%b cnt=%0d want 1/0/8", cmd_ready, res_valid, op_cnt); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        issue(OP_XOR, 4'd6, 4'd3, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++; if ({alu_sel, alu_a, alu_b} !== 12'h0 || op_cnt !== 8'd0) begin fails++; $display("FAIL midrst_alu: got sel=%h a=%h b=%h cnt=%0d want 0", alu_sel, alu_a, alu_b, op_cnt); end
        tests++; if ({res_valid, res_err, res_data} !== 18'h0 || cmd_ready !== 1'b0) begin fails++; $display("FAIL midrst_res: got v=%b e=%b d=%h rdy=%b want 0/0/0000/0", res_valid, res_err, res_data, cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0) seen++;
        end
        tests++; if (seen != 0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL midrst_no_resp: got %0d valid cycles rdy=%b want 0/1", seen, cmd_ready); end
    endtask

    task automatic test_chain_after_reset_and_wrap();
        int lat;
        issue(OP_INC, 4'd7, 4'd0, 1'b1);
        tests++; if (alu_a !== 4'd0) begin fails++; $display("FAIL chain0_operand: got %0d want 0", alu_a); end
        wait_res(lat);
        tests++; if (res_data !== 16'h0001) begin fails++; $display("FAIL chain0_result: got %h want 0001", res_data); end
        handoff();
        for (int n = 0; n < 254; n++) begin
            issue(OP_ADD, 4'd0, 4'd0, 1'b0);
            wait_res(lat);
            handoff();
        end
        tests++; if (op_cnt !== 8'hFF) begin fails++; $display("FAIL wrap_pre: got %0d want 255", op_cnt); end
        issue(OP_DEC, 4'd0, 4'd0, 1'b0);
        wait_res(lat);
        tests++; if (res_data !== 16'hFFFF || res_err !== 1'b0) begin fails++; $display("FAIL dec_zero: got d=%h e=%b want FFFF/0", res_data, res_err); end
        handoff();
        tests++; if (op_cnt !== 8'h00) begin fails++; $display("FAIL wrap_post: got %0d want 0", op_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_div_zero();
        test_chain();
        test_backpressure();
        test_reset_mid_op();
        test_chain_after_reset_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Sequential initiator for the team's 4-bit combinational ALU (16-bit result, 4-bit sel opcode).
- Accepts operation commands over a valid/ready handshake and drives sel/a/b to the attached ALU.
- Captures the ALU result after a settle window and returns it over a second valid/ready handshake.
- Traps divide/modulo by zero, supports result chaining, and counts completed operations.

Parameters:
- SETTLE_CYC, 1, cycles ALU inputs are held stable before alu_op is captured; legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  issuer can accept a command.
- cmd_sel  input  4  ALU opcode.
- cmd_a  input  4  operand a.
- cmd_b  input  4  operand b.
- cmd_chain  input  1  when 1, use last_res[3:0] in place of cmd_a.
- alu_sel  output  4  opcode to ALU.
- alu_a  output  4  operand a to ALU.
- alu_b  output  4  operand b to ALU.
- alu_op  input  16  ALU result.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_data  output  16  captured result, or 16'hFFFF on error.
- res_err  output  1  divide/modulo by zero trapped.
- op_cnt  output  CNT_W  count of results handed off; wraps modulo 2^CNT_W.

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset behaviour: on rst assertion, immediately set state IDLE and clear alu_sel, alu_a, alu_b, res_data, res_err, res_valid, op_cnt, last_res and the settle counter.
- cmd_ready = (state==IDLE) & ~rst.
- Reset mid-operation discards the in-flight command; no response is produced.
- The attached ALU re-evaluates only when sel changes. Every issue therefore begins with a one-cycle kick at the inverted opcode.
- FSM states: IDLE, KICK, SETTLE, RESP.
- IDLE, accept edge (cmd_valid & cmd_ready):
  - Latch sel and b, and a (= cmd_chain ? last_res[3:0] : cmd_a).
  - If sel is 4'b0011 or 4'b0100 and b==0: go to RESP with res_data=16'hFFFF and res_err=1. ALU outputs are left unchanged and last_res is unchanged.
  - Otherwise: alu_a/alu_b get the operands, alu_sel=~sel, go to KICK.
- KICK (one cycle): next edge sets alu_sel=sel and cnt=SETTLE_CYC, go to SETTLE.
- SETTLE: each edge decrements cnt. On the edge where cnt==1:
  - res_data<=alu_op, last_res<=alu_op, res_err<=0, res_valid<=1, go to RESP.
- Latency: res_valid rises 1+SETTLE_CYC edges after the accept edge on the normal path, and 1 edge after it on the error path.
- RESP: res_valid, res_data and res_err are held stable until res_ready.
  - On the edge with res_valid & res_ready: res_valid<=0, op_cnt<=op_cnt+1 (errors count too), go to IDLE.
- No same-cycle bypass. cmd_ready rises the cycle after hand-off. Peak throughput is one command per SETTLE_CYC+3 cycles.
- alu_sel/alu_a/alu_b hold their last driven values in IDLE and RESP.
- No input changes are sampled outside the accept edge.
- Chain with no prior result uses last_res=0 (reset value).
- The result is captured without truncation. Subtraction underflow and decrement of 0 appear exactly as alu_op presents them.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=4'b0000 … OP_DEC=4'b1111 (incl. OP_DIV=4'b0011, OP_MOD=4'b0100);
  - the state encoding;
  - ERR_RESULT=16'hFFFF.
- No sub-module; the issuer is one module.
- The bench instantiates the existing ALU on the alu_* ports.

Test Plan:
- Reset release, then cmd sel=0000 a=3 b=5, SETTLE_CYC=1 -> alu_sel shows 1111 for one cycle then 0000; res_valid 2 edges after accept; res_data=16'h0008, res_err=0, op_cnt=1.
- Two back-to-back commands with identical sel=0010 (a=3,b=4 then a=2,b=7) -> res_data 16'h000C then 16'h000E. Proves the kick forces ALU re-evaluation.
- sel=0011 a=9 b=0, then sel=0100 a=9 b=0 -> each responds 1 edge after accept with res_data=16'hFFFF, res_err=1; alu_* outputs unchanged; op_cnt increments by 2.
- Chain: sel=0000 a=2 b=3 (res 5), then cmd_chain=1 sel=1100 b=0 -> alu_a=5, res_data=16'h000A.
- Backpressure: res_ready held low 10 cycles -> res_valid/res_data stable, cmd_ready=0 throughout; hand-off edge returns to IDLE and cmd_ready=1 the next cycle.
- rst pulsed during SETTLE -> all outputs cleared immediately, no res_valid afterwards; op_cnt wraps from 2^CNT_W-1 to 0 on the next completion.
